// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter onto one shared memory port with anti-starvation
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_dm
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        DM_WAIT
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak, streak_n;
    logic          mem_req_n, mem_we_n, if_valid_n, dm_valid_n;
    logic [31:0]   mem_addr_n, mem_wdata_n, if_rdata_n, dm_rdata_n;
    logic          if_live, dm_live, starve;

    // A port whose completion pulse is showing cannot win arbitration that cycle.
    assign if_live = if_req & ~if_valid;
    assign dm_live = dm_req & ~dm_valid;
    assign starve  = if_live && (streak == STREAK_MAX);

    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

    always_comb begin
        state_n     = state;
        streak_n    = streak;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        if_valid_n  = 1'b0;
        dm_valid_n  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_live && !starve) begin
                    state_n     = DM_WAIT;
                    mem_req_n   = 1'b1;
                    mem_we_n    = dm_we;
                    mem_addr_n  = dm_addr & 32'hFFFF_FFFC;
                    mem_wdata_n = dm_wdata;
                    if (!if_req)
                        streak_n = '0;
                    else if (streak != STREAK_MAX)
                        streak_n = streak + 1'b1;
                end else if (if_live) begin
                    state_n     = IF_WAIT;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = if_addr & 32'hFFFF_FFFC;
                    mem_wdata_n = dm_wdata;
                    streak_n    = '0;
                end
            end
            IF_WAIT: begin
                if (mem_ready) begin
                    state_n    = IDLE;
                    mem_req_n  = 1'b0;
                    if_valid_n = 1'b1;
                    if_rdata_n = mem_rdata;
                end
            end
            DM_WAIT: begin
                if (mem_ready) begin
                    state_n    = IDLE;
                    mem_req_n  = 1'b0;
                    dm_valid_n = 1'b1;
                    // Stores leave the last load result visible.
                    if (!mem_we)
                        dm_rdata_n = mem_rdata;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            streak    <= streak_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
            if_valid  <= if_valid_n;
            dm_valid  <= dm_valid_n;
        end
    end

endmodule
